// File: rtl/ql_cfg_pkg.sv
// Shared definitions for the region-0 BL/WL configuration loader.
//   cfg_state_t      : loader FSM state encoding
//   QL_BL_WIDTH/ROWS : region-0 array geometry defaults
//   words_per_frame  : input words needed to fill one bit-line frame
//   idx_width        : width of an index/counter over n values (minimum 1 bit)
package ql_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } cfg_state_t;

    localparam int QL_BL_WIDTH = 514;
    localparam int QL_WL_ROWS  = 407;

    function automatic int words_per_frame(input int bl, input int w);
        return (bl + w - 1) / w;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ql_cfg_frame_asm.sv
// Bit-line frame assembler.
// Collects WPF input words into one BL_WIDTH-bit frame. Word k lands on
// frame[k*IN_W +: IN_W] with word bit i on frame[k*IN_W+i]; bits of the last
// word that fall beyond BL_WIDTH are dropped.
// Ports:
//   clk, srst : clock, synchronous active-high reset (clears frame and wc)
//   load      : accept 'word' into slot wc, then advance wc
//   clear     : restart the word counter at slot 0 (frame contents kept)
//   word      : input word
//   wc        : current word slot
//   frame     : assembled frame, index [0:BL_WIDTH-1]
module ql_cfg_frame_asm
    import ql_cfg_pkg::*;
#(
    parameter int BL_WIDTH = QL_BL_WIDTH,
    parameter int IN_W     = 32,
    parameter int WPF      = words_per_frame(BL_WIDTH, IN_W),
    parameter int WC_W     = idx_width(WPF)
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                load,
    input  logic                clear,
    input  logic [IN_W-1:0]     word,
    output logic [WC_W-1:0]     wc,
    output logic [0:BL_WIDTH-1] frame
);

    logic [WC_W-1:0]     wc_reg;
    logic [0:BL_WIDTH-1] frame_reg;
    logic [0:BL_WIDTH-1] frame_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            wc_reg <= '0;
        end else if (clear) begin
            wc_reg <= '0;
        end else if (load) begin
            wc_reg <= (wc_reg == WC_W'(WPF - 1)) ? '0 : wc_reg + 1'b1;
        end
    end

    // Each frame bit has exactly one source slot/bit; bits past BL_WIDTH
    // simply have no frame bit to land on, which is the truncation.
    genvar gi;
    generate
        for (gi = 0; gi < BL_WIDTH; gi++) begin : g_bit
            localparam int WORD_IDX = gi / IN_W;
            localparam int BIT_IDX  = gi % IN_W;
            assign frame_next[gi] = (load && (wc_reg == WC_W'(WORD_IDX)))
                                    ? word[BIT_IDX] : frame_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            frame_reg <= '0;
        end else begin
            frame_reg <= frame_next;
        end
    end

    assign wc    = wc_reg;
    assign frame = frame_reg;

endmodule

// File: rtl/ql_bank_cfg_loader.sv
// Region-0 memory-bank configuration loader.
// Streams the bitstream in as IN_W-bit words, assembles one bit-line frame per
// word-line row, presents it on bl, waits SETUP_CYC cycles, pulses the row's
// word line for WL_PULSE cycles, idles one HOLD cycle, then moves to the next
// row. After the last row cfg_done is raised and held until the next start.
// Ports:
//   clk, global_reset : clock, synchronous active-high reset
//   cfg_start         : begin a load (honoured in IDLE/DONE only)
//   cfg_abort         : abandon an active load (honoured while busy only)
//   in_data/valid/ready : bitstream word stream
//   bl                : bit lines [0:BL_WIDTH-1]
//   wl                : word lines [0:WL_ROWS-1], one-hot during PULSE, else 0
//   cfg_busy          : loader active (not IDLE/DONE)
//   cfg_done          : sticky completion flag
//   cfg_row           : current row index
module ql_bank_cfg_loader
    import ql_cfg_pkg::*;
#(
    parameter int BL_WIDTH  = QL_BL_WIDTH,
    parameter int WL_ROWS   = QL_WL_ROWS,
    parameter int IN_W      = 32,
    parameter int SETUP_CYC = 1,
    parameter int WL_PULSE  = 2
) (
    input  logic                          clk,
    input  logic                          global_reset,
    input  logic                          cfg_start,
    input  logic                          cfg_abort,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [0:BL_WIDTH-1]           bl,
    output logic [0:WL_ROWS-1]            wl,
    output logic                          cfg_busy,
    output logic                          cfg_done,
    output logic [idx_width(WL_ROWS)-1:0] cfg_row
);

    localparam int WPF     = words_per_frame(BL_WIDTH, IN_W);
    localparam int WC_W    = idx_width(WPF);
    localparam int ROW_W   = idx_width(WL_ROWS);
    localparam int CYC_MAX = (SETUP_CYC > WL_PULSE) ? SETUP_CYC : WL_PULSE;
    localparam int CYC_W   = idx_width(CYC_MAX);

    cfg_state_t         state_reg, state_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [CYC_W-1:0]   cyc_reg, cyc_next;
    logic               ready_reg, ready_next;
    logic               done_reg, done_next;
    logic               busy_reg, busy_next;
    logic [0:WL_ROWS-1] wl_reg, wl_next;

    logic               asm_load;
    logic               asm_clear;
    logic [WC_W-1:0]    asm_wc;
    logic               busy_now;
    logic               accept;

    ql_cfg_frame_asm #(
        .BL_WIDTH (BL_WIDTH),
        .IN_W     (IN_W),
        .WPF      (WPF),
        .WC_W     (WC_W)
    ) u_frame_asm (
        .clk   (clk),
        .srst  (global_reset),
        .load  (asm_load),
        .clear (asm_clear),
        .word  (in_data),
        .wc    (asm_wc),
        .frame (bl)
    );

    assign busy_now = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign accept   = in_valid && ready_reg;

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        cyc_next   = cyc_reg;
        ready_next = ready_reg;
        done_next  = done_reg;
        asm_load   = 1'b0;
        asm_clear  = 1'b0;

        // Abort outranks everything, so a word offered in the same cycle is
        // never written (asm_load stays low).
        if (cfg_abort && busy_now) begin
            state_next = ST_IDLE;
            ready_next = 1'b0;
            done_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (cfg_start) begin
                        state_next = ST_LOAD;
                        row_next   = '0;
                        ready_next = 1'b1;
                        done_next  = 1'b0;
                        asm_clear  = 1'b1;
                    end
                end
                ST_LOAD: begin
                    asm_load = accept;
                    if (accept && (asm_wc == WC_W'(WPF - 1))) begin
                        state_next = ST_SETUP;
                        ready_next = 1'b0;
                        cyc_next   = '0;
                    end
                end
                ST_SETUP: begin
                    if (cyc_reg == CYC_W'(SETUP_CYC - 1)) begin
                        state_next = ST_PULSE;
                        cyc_next   = '0;
                    end else begin
                        cyc_next = cyc_reg + 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cyc_reg == CYC_W'(WL_PULSE - 1)) begin
                        state_next = ST_HOLD;
                        cyc_next   = '0;
                    end else begin
                        cyc_next = cyc_reg + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (row_reg == ROW_W'(WL_ROWS - 1)) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_LOAD;
                        row_next   = row_reg + 1'b1;
                        ready_next = 1'b1;
                        asm_clear  = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    ready_next = 1'b0;
                end
            endcase
        end

        busy_next = (state_next != ST_IDLE) && (state_next != ST_DONE);
    end

    // Word-line decode from the next state: wl is registered alongside the
    // state, so it can only be high while the FSM sits in PULSE.
    genvar gi;
    generate
        for (gi = 0; gi < WL_ROWS; gi++) begin : g_wl
            assign wl_next[gi] = (state_next == ST_PULSE) && (row_next == ROW_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (global_reset) begin
            state_reg <= ST_IDLE;
            row_reg   <= '0;
            cyc_reg   <= '0;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            wl_reg    <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            cyc_reg   <= cyc_next;
            ready_reg <= ready_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            wl_reg    <= wl_next;
        end
    end

    assign in_ready = ready_reg;
    assign wl       = wl_reg;
    assign cfg_busy = busy_reg;
    assign cfg_done = done_reg;
    assign cfg_row  = row_reg;

endmodule
